uart_tx: RTL and testbench

- 8N1 UART transmitter with a small input FIFO and CTS# flow control.
- Sits alongside the existing UART receiver on the USB-serial PMOD and drives the TXD pin (C5 / PMODL3).
- Accepts bytes from fabric logic on a valid/ready handshake, buffers them, and serialises them LSB-first at the configured baud rate.
- Its output is the stimulus source for receiver loopback benches.

---
 rtl/uart_tx.sv | 94 +++++++++
 tb/tb_uart_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with byte FIFO and CTS# gating at frame start
module uart_tx #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 16,
    parameter bit USE_CTS      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic                          cts,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [1:0]    cts_sync;
    logic          cts_ok, push, pop, bit_end;

    always_comb begin
        data_ready = !reset && fifo_count != FULL;
        cts_ok     = !USE_CTS || !cts_sync[1];
        push       = data_valid && data_ready;
        bit_end    = baud_cnt == BAUD_MAX;
        // a pop both starts a frame from IDLE and chains the next frame straight out of STOP
        pop        = fifo_count != '0 && cts_ok && (state == IDLE || (state == STOP && bit_end));
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            cts_sync   <= 2'b11;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            cts_sync   <= {cts_sync[0], cts};
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            baud_cnt   <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (pop) begin
                shift <= mem[rd_ptr];
                tx    <= 1'b0;
                busy  <= 1'b1;
                state <= START;
            end else if (bit_end) begin
                case (state)
                    START: begin
                        tx      <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        tx      <= bit_cnt == 3'd7 ? 1'b1 : shift[1];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= bit_cnt == 3'd7 ? STOP : DATA;
                    end
                    STOP: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;
    logic       clk = 0;
    logic       reset = 1;
    logic [7:0] data_in = 0;
    logic       data_valid = 0;
    logic       data_ready;
    logic       cts = 0;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    int         n_pass = 0;
    int         n_total = 0;

    uart_tx #(.CLK_FREQ(1000000), .BAUD(250000), .FIFO_DEPTH(4), .USE_CTS(1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .cts(cts), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // expected line level k cycles into a frame carrying byte b (4 clocks per bit)
    function automatic logic line_bit(input logic [7:0] b, input int k);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[k / 4];
    endfunction

    task automatic test_reset;
        reset = 1;
        tick;
        tick;
        n_total++;
        if ({tx, busy, fifo_count, data_ready} !== {1'b1, 1'b0, 3'd0, 1'b0}) $display("FAIL reset_state: got tx/busy/cnt/rdy=%b expected 1_0_000_0", {tx, busy, fifo_count, data_ready});
        else n_pass++;
        reset = 0;
        #1;
        n_total++;
        if (data_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", data_ready);
        else n_pass++;
        repeat (3) tick;
        n_total++;
        if ({tx, busy} !== 2'b10) $display("FAIL reset_idle: got tx/busy=%b expected 10", {tx, busy});
        else n_pass++;
    endtask

    task automatic test_single;
        logic [7:0] bytes [2];
        bytes[0] = 8'hA5;
        bytes[1] = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            data_in = bytes[i];
            data_valid = 1;
            tick;
            data_valid = 0;
            n_total++;
            if ({fifo_count, tx, busy} !== {3'd1, 1'b1, 1'b0}) $display("FAIL single_push: got cnt/tx/busy=%b expected 00110", {fifo_count, tx, busy});
            else n_pass++;
            for (int k = 0; k < 40; k++) begin
                tick;
                n_total++;
                if ({tx, busy} !== {line_bit(bytes[i], k), 1'b1}) $display("FAIL single_line byte=%h k=%0d: got tx/busy=%b expected %b1", bytes[i], k, {tx, busy}, line_bit(bytes[i], k));
                else n_pass++;
                if (k == 0) begin
                    n_total++;
                    if (fifo_count !== 3'd0) $display("FAIL single_pop_count: got %0d expected 0", fifo_count);
                    else n_pass++;
                end
            end
            tick;
            n_total++;
            if ({tx, busy} !== 2'b10) $display("FAIL single_end: got tx/busy=%b expected 10", {tx, busy});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b [3];
        int peak;
        b[0] = 8'h00;
        b[1] = 8'hFF;
        b[2] = 8'h3C;
        peak = 0;
        for (int j = 0; j < 122; j++) begin
            data_valid = j < 3;
            data_in = j < 3 ? b[j] : 8'h00;
            tick;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            n_total++;
            if (j == 0 || j == 121) begin
                if ({tx, busy} !== 2'b10) $display("FAIL b2b_idle j=%0d: got tx/busy=%b expected 10", j, {tx, busy});
                else n_pass++;
            end else begin
                if ({tx, busy} !== {line_bit(b[(j-1)/40], (j-1)%40), 1'b1}) $display("FAIL b2b_line j=%0d: got tx/busy=%b expected %b1", j, {tx, busy}, line_bit(b[(j-1)/40], (j-1)%40));
                else n_pass++;
            end
        end
        data_valid = 0;
        n_total++;
        if (peak !== 2) $display("FAIL b2b_peak: got %0d expected 2", peak);
        else n_pass++;
    endtask

    task automatic test_cts_full;
        logic [7:0] q [6];
        int acc, n;
        logic rdy, stayed_high;
        for (int i = 0; i < 6; i++) q[i] = 8'($urandom);
        cts = 1;
        repeat (3) tick;
        acc = 0;
        stayed_high = 1;
        for (int k = 0; k < 6; k++) begin
            data_in = q[acc];
            data_valid = 1;
            rdy = data_ready;
            tick;
            if (rdy) acc++;
            if (tx !== 1'b1) stayed_high = 0;
            if (k == 3) begin
                n_total++;
                if (data_ready !== 1'b0) $display("FAIL cts_full_ready: got %b expected 0", data_ready);
                else n_pass++;
            end
        end
        data_valid = 0;
        repeat (5) begin
            tick;
            if (tx !== 1'b1) stayed_high = 0;
        end
        n_total++;
        if (acc !== 4) $display("FAIL cts_accepted: got %0d expected 4", acc);
        else n_pass++;
        n_total++;
        if (fifo_count !== 3'd4) $display("FAIL cts_count: got %0d expected 4", fifo_count);
        else n_pass++;
        n_total++;
        if (stayed_high !== 1'b1) $display("FAIL cts_hold_tx: got %b expected 1", stayed_high);
        else n_pass++;
        cts = 0;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            tick;
            n++;
        end
        n_total++;
        if (tx !== 1'b0 || n > 3) $display("FAIL cts_release_latency: got %0d cycles expected <=3", n);
        else n_pass++;
        for (int j = 0; j < 160; j++) begin
            n_total++;
            if (tx !== line_bit(q[j/40], j%40)) $display("FAIL cts_frames j=%0d: got %b expected %b", j, tx, line_bit(q[j/40], j%40));
            else n_pass++;
            tick;
        end
        n_total++;
        if ({tx, busy, data_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 3'd0}) $display("FAIL cts_drain: got tx/busy/rdy/cnt=%b expected 101000", {tx, busy, data_ready, fifo_count});
        else n_pass++;
    endtask

    task automatic test_cts_midframe;
        logic [7:0] r;
        int n;
        r = 8'($urandom);
        for (int j = 0; j < 61; j++) begin
            data_valid = j < 2;
            data_in = j == 0 ? 8'h41 : r;
            tick;
            if (j >= 1 && j <= 40) begin
                n_total++;
                if (tx !== line_bit(8'h41, j-1)) $display("FAIL mid_frame j=%0d: got %b expected %b", j, tx, line_bit(8'h41, j-1));
                else n_pass++;
            end else if (j > 40) begin
                n_total++;
                if (tx !== 1'b1) $display("FAIL mid_wait j=%0d: got tx=%b expected 1", j, tx);
                else n_pass++;
            end
            if (j == 13) cts = 1;
        end
        data_valid = 0;
        n_total++;
        if ({busy, fifo_count} !== {1'b0, 3'd1}) $display("FAIL mid_queued: got busy/cnt=%b expected 0001", {busy, fifo_count});
        else n_pass++;
        cts = 0;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            tick;
            n++;
        end
        n_total++;
        if (tx !== 1'b0 || n > 3) $display("FAIL mid_resume_latency: got %0d cycles expected <=3", n);
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            n_total++;
            if (tx !== line_bit(r, k)) $display("FAIL mid_second k=%0d: got %b expected %b", k, tx, line_bit(r, k));
            else n_pass++;
            tick;
        end
        n_total++;
        if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) $display("FAIL mid_end: got tx/busy/cnt=%b expected 10000", {tx, busy, fifo_count});
        else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b0;
        logic quiet;
        b0 = 8'($urandom);
        for (int j = 0; j < 18; j++) begin
            data_valid = j < 2;
            data_in = j == 0 ? b0 : 8'($urandom);
            tick;
        end
        data_valid = 0;
        n_total++;
        if (tx !== line_bit(b0, 16)) $display("FAIL rst_mid_bit3: got %b expected %b", tx, line_bit(b0, 16));
        else n_pass++;
        reset = 1;
        tick;
        n_total++;
        if ({tx, busy, fifo_count, data_ready} !== {1'b1, 1'b0, 3'd0, 1'b0}) $display("FAIL rst_mid_state: got tx/busy/cnt/rdy=%b expected 1_0_000_0", {tx, busy, fifo_count, data_ready});
        else n_pass++;
        reset = 0;
        #1;
        n_total++;
        if (data_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", data_ready);
        else n_pass++;
        quiet = 1;
        repeat (60) begin
            tick;
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) quiet = 0;
        end
        n_total++;
        if (quiet !== 1'b1) $display("FAIL rst_mid_quiet: got %b expected 1", quiet);
        else n_pass++;
    endtask

    task automatic test_loopback;
        logic [7:0] q [8];
        q[0] = 8'h55;
        q[1] = 8'h00;
        q[2] = 8'hFF;
        for (int i = 3; i < 8; i++) q[i] = 8'($urandom);
        fork
            begin
                int n;
                logic r;
                for (int i = 0; i < 8; i++) begin
                    data_in = q[i];
                    data_valid = 1;
                    n = 0;
                    do begin
                        r = data_ready;
                        tick;
                        n++;
                    end while (!r && n < 400);
                end
                data_valid = 0;
            end
            begin
                int n;
                logic [7:0] rb;
                logic s;
                for (int i = 0; i < 8; i++) begin
                    n = 0;
                    while (tx !== 1'b0 && n < 400) begin
                        tick;
                        n++;
                    end
                    n_total++;
                    if (tx !== 1'b0) begin
                        $display("FAIL lb_timeout frame=%0d: no start bit within %0d cycles", i, n);
                        break;
                    end
                    n_pass++;
                    repeat (2) tick;
                    s = tx;
                    for (int k = 0; k < 8; k++) begin
                        repeat (4) tick;
                        rb[k] = tx;
                    end
                    repeat (4) tick;
                    n_total++;
                    if ({s, rb, tx} !== {1'b0, q[i], 1'b1}) $display("FAIL lb_byte frame=%0d: got start/data/stop=%b_%h_%b expected 0_%h_1", i, s, rb, tx, q[i]);
                    else n_pass++;
                    repeat (2) tick;
                end
            end
        join
        repeat (3) tick;
        n_total++;
        if ({tx, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) $display("FAIL lb_end: got tx/busy/cnt=%b expected 10000", {tx, busy, fifo_count});
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_cts_full;
        test_cts_midframe;
        test_reset_midframe;
        test_loopback;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
